// File: rtl/wavetable_pkg.sv
// Shared types and width helpers for the wavetable playback bank.
package wavetable_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    MIX
  } state_e;

  // Bank select width; a single bank still needs one address bit.
  function automatic int bank_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wavetable_ram.sv
// Single-port byte-enabled sample RAM with a registered read; contents survive reset.
module wavetable_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write: a write cycle returns the old word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) begin
          mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wavetable_bank.sv
// Multi-channel wavetable player: per-channel phase accumulators read banked RAM,
// emit one sample per enabled channel per frame and a signed frame mix.
module wavetable_bank
  import wavetable_pkg::*;
#(
  parameter int  NUM_BANKS = 3,
  parameter int  ADDR_W    = 8,
  parameter int  DATA_W    = 16,
  parameter int  PHASE_W   = 24,
  localparam int BANK_W    = bank_w(NUM_BANKS),
  localparam int BE_W      = DATA_W / 8,
  localparam int MIX_W     = DATA_W + BANK_W
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [BANK_W+ADDR_W-1:0]     s1_address,
  input  logic                         s1_chipselect,
  input  logic                         s1_clken,
  input  logic                         s1_write,
  input  logic [DATA_W-1:0]            s1_writedata,
  input  logic [BE_W-1:0]              s1_byteenable,
  output logic [DATA_W-1:0]            s1_readdata,
  input  logic                         sample_tick,
  input  logic [NUM_BANKS-1:0]         chan_enable,
  input  logic [NUM_BANKS*PHASE_W-1:0] phase_inc,
  output logic                         smp_valid,
  output logic [BANK_W-1:0]            smp_chan,
  output logic [DATA_W-1:0]            smp_data,
  output logic                         mix_valid,
  output logic [MIX_W-1:0]             mix_data,
  output logic                         busy,
  output logic                         overrun
);

  logic                acc;
  logic [BANK_W-1:0]   acc_bank;
  logic [ADDR_W-1:0]   acc_word;

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   chan_q, chan_d;
  logic [NUM_BANKS-1:0] en_q, en_d;
  logic [PHASE_W-1:0]  inc_q [NUM_BANKS];
  logic [PHASE_W-1:0]  inc_d [NUM_BANKS];
  logic [PHASE_W-1:0]  phase_q [NUM_BANKS];
  logic [PHASE_W-1:0]  phase_d [NUM_BANKS];
  logic [MIX_W-1:0]    accum_q, accum_d;

  logic                smp_valid_q, smp_valid_d;
  logic [BANK_W-1:0]   smp_chan_q, smp_chan_d;
  logic [DATA_W-1:0]   smp_data_q, smp_data_d;
  logic                mix_valid_q, mix_valid_d;
  logic [MIX_W-1:0]    mix_data_q, mix_data_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic                rd_pend_q, rd_pend_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;

  logic [DATA_W-1:0]   ram_rdata [NUM_BANKS];
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   cur_word;
  logic                cpu_hit;
  logic                last_chan;
  logic                advance;

  assign acc      = s1_chipselect & s1_clken;
  assign acc_bank = s1_address[ADDR_W +: BANK_W];
  assign acc_word = s1_address[ADDR_W-1:0];

  // The CPU always wins a bank; the player only reads when the bank is free.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic cpu_sel;
      logic fsm_rd;
      assign cpu_sel = acc && (acc_bank == BANK_W'(gi));
      assign fsm_rd  = (state_q == FETCH) && (chan_q == BANK_W'(gi)) && en_q[gi] && !cpu_sel;

      wavetable_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_ram (
        .clk   (clk_clk),
        .en    (cpu_sel | fsm_rd),
        .we    (cpu_sel & s1_write),
        .be    (s1_byteenable),
        .addr  (cpu_sel ? acc_word : phase_q[gi][PHASE_W-1 -: ADDR_W]),
        .wdata (s1_writedata),
        .rdata (ram_rdata[gi])
      );
    end
  endgenerate

  assign cur_word  = ram_rdata[chan_q];
  assign cpu_hit   = acc && (acc_bank == chan_q);
  assign last_chan = (chan_q == BANK_W'(NUM_BANKS - 1));

  // CPU read port: RAM output is live the cycle after the access, then held.
  always_comb begin
    rd_word = '0;
    if (int'(rd_bank_q) < NUM_BANKS) begin
      rd_word = ram_rdata[rd_bank_q];
    end
    s1_readdata = rd_pend_q ? rd_word : readdata_q;
    readdata_d  = s1_readdata;
    rd_pend_d   = acc && !s1_write;
    rd_bank_d   = acc ? acc_bank : rd_bank_q;
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    en_d        = en_q;
    inc_d       = inc_q;
    phase_d     = phase_q;
    accum_d     = accum_q;
    smp_valid_d = 1'b0;
    smp_chan_d  = smp_chan_q;
    smp_data_d  = smp_data_q;
    mix_valid_d = 1'b0;
    mix_data_d  = mix_data_q;
    busy_d      = busy_q;
    overrun_d   = sample_tick && (state_q != IDLE);
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          en_d = chan_enable;
          for (int i = 0; i < NUM_BANKS; i++) begin
            inc_d[i] = phase_inc[i*PHASE_W +: PHASE_W];
          end
          chan_d  = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!en_q[chan_q]) begin
          phase_d[chan_q] = '0;
          advance         = 1'b1;
        end else if (!cpu_hit) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Sample is captured here so a CPU access during EMIT cannot disturb it.
        smp_valid_d = 1'b1;
        smp_chan_d  = chan_q;
        smp_data_d  = cur_word;
        accum_d     = accum_q + {{BANK_W{cur_word[DATA_W-1]}}, cur_word};
        state_d     = EMIT;
      end
      EMIT: begin
        phase_d[chan_q] = phase_q[chan_q] + inc_q[chan_q];
        advance         = 1'b1;
      end
      MIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last_chan) begin
        mix_valid_d = 1'b1;
        mix_data_d  = accum_d;
        accum_d     = '0;
        state_d     = MIX;
      end else begin
        chan_d  = chan_q + 1'b1;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      en_q        <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        inc_q[i]   <= '0;
        phase_q[i] <= '0;
      end
      accum_q     <= '0;
      smp_valid_q <= 1'b0;
      smp_chan_q  <= '0;
      smp_data_q  <= '0;
      mix_valid_q <= 1'b0;
      mix_data_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_bank_q   <= '0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      en_q        <= en_d;
      inc_q       <= inc_d;
      phase_q     <= phase_d;
      accum_q     <= accum_d;
      smp_valid_q <= smp_valid_d;
      smp_chan_q  <= smp_chan_d;
      smp_data_q  <= smp_data_d;
      mix_valid_q <= mix_valid_d;
      mix_data_q  <= mix_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      rd_pend_q   <= rd_pend_d;
      rd_bank_q   <= rd_bank_d;
      readdata_q  <= readdata_d;
    end
  end

  assign smp_valid = smp_valid_q;
  assign smp_chan  = smp_chan_q;
  assign smp_data  = smp_data_q;
  assign mix_valid = mix_valid_q;
  assign mix_data  = mix_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_wavetable_bank.sv
// Directed plus randomized bench for wavetable_bank against a frame-level model.
module tb_wavetable_bank;
  localparam int NB = 3;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PW = 24;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BW+AW-1:0]  s1_address;
  logic              s1_chipselect, s1_clken, s1_write;
  logic [DW-1:0]     s1_writedata;
  logic [1:0]        s1_byteenable;
  logic [DW-1:0]     s1_readdata;
  logic              sample_tick;
  logic [NB-1:0]     chan_enable;
  logic [NB*PW-1:0]  phase_inc;
  logic              smp_valid;
  logic [BW-1:0]     smp_chan;
  logic [DW-1:0]     smp_data;
  logic              mix_valid;
  logic [DW+BW-1:0]  mix_data;
  logic              busy, overrun;

  always #5 clk = ~clk;

  wavetable_bank dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .s1_address    (s1_address),
    .s1_chipselect (s1_chipselect),
    .s1_clken      (s1_clken),
    .s1_write      (s1_write),
    .s1_writedata  (s1_writedata),
    .s1_byteenable (s1_byteenable),
    .s1_readdata   (s1_readdata),
    .sample_tick   (sample_tick),
    .chan_enable   (chan_enable),
    .phase_inc     (phase_inc),
    .smp_valid     (smp_valid),
    .smp_chan      (smp_chan),
    .smp_data      (smp_data),
    .mix_valid     (mix_valid),
    .mix_data      (mix_data),
    .busy          (busy),
    .overrun       (overrun)
  );

  // Reference state: shadow RAM image and per-channel phase.
  logic [DW-1:0] mem [NB][256];
  logic [PW-1:0] ph  [NB];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int bank, input int word, input logic [15:0] data,
                           input logic [1:0] be, input logic clken);
    logic [1:0] b;
    logic [7:0] w;
    b = bank[1:0];
    w = word[7:0];
    s1_address    = {b, w};
    s1_writedata  = data;
    s1_byteenable = be;
    s1_write      = 1'b1;
    s1_chipselect = 1'b1;
    s1_clken      = clken;
    step();
    s1_chipselect = 1'b0;
    s1_write      = 1'b0;
    s1_clken      = 1'b0;
    if (clken && bank < NB) begin
      if (be[0]) mem[bank][word][7:0]  = data[7:0];
      if (be[1]) mem[bank][word][15:8] = data[15:8];
    end
  endtask

  task automatic cpu_read(input string tag, input int bank, input int word);
    logic [1:0]    b;
    logic [7:0]    w;
    logic [DW-1:0] exp;
    b   = bank[1:0];
    w   = word[7:0];
    exp = (bank < NB) ? mem[bank][word] : '0;
    s1_address    = {b, w};
    s1_write      = 1'b0;
    s1_chipselect = 1'b1;
    s1_clken      = 1'b1;
    step();
    s1_chipselect = 1'b0;
    s1_clken      = 1'b0;
    check({tag, "_rd"}, 32'(s1_readdata), 32'(exp));
    $display("read  bank=%0d word=%02h data=%04h", bank, word, s1_readdata);
    step();
    check({tag, "_hold"}, 32'(s1_readdata), 32'(exp));
  endtask

  task automatic run_frame(input string tag, input logic [NB-1:0] en,
                           input logic [PW-1:0] i0, input logic [PW-1:0] i1,
                           input logic [PW-1:0] i2, input int stall, input int extra_at);
    int            exp_chan[$];
    logic [DW-1:0] exp_data[$];
    logic [PW-1:0] inc [NB];
    int            sum, pop, exp_busy, nbusy, nmix, nover;
    logic [DW+BW-1:0] exp_mix;
    logic [DW-1:0] last_smp, stall_exp;
    bit            done, any;
    inc[0] = i0; inc[1] = i1; inc[2] = i2;
    sum = 0; pop = 0; any = 0; last_smp = smp_data;
    stall_exp = mem[0][9];
    for (int c = 0; c < NB; c++) begin
      if (en[c]) begin
        exp_chan.push_back(c);
        exp_data.push_back(mem[c][ph[c][PW-1 -: AW]]);
        sum += int'($signed(mem[c][ph[c][PW-1 -: AW]]));
        last_smp = mem[c][ph[c][PW-1 -: AW]];
        ph[c] = ph[c] + inc[c];
        pop++;
        any = 1;
      end else begin
        ph[c] = '0;
      end
    end
    exp_mix  = sum[DW+BW-1:0];
    exp_busy = 3 * pop + (NB - pop) + 1 + stall;

    chan_enable = en;
    phase_inc   = {i2, i1, i0};
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chan_enable = $urandom;
    phase_inc   = {$urandom, $urandom, $urandom};
    nbusy = 0; nmix = 0; nover = 0; done = 0;
    for (int i = 0; i < 80; i++) begin
      if (smp_valid) begin
        if (exp_chan.size() == 0) begin
          check({tag, "_extra_smp"}, 32'(smp_valid), 32'd0);
        end else begin
          check({tag, "_smp_chan"}, 32'(smp_chan), 32'(exp_chan.pop_front()));
          check({tag, "_smp_data"}, 32'(smp_data), 32'(exp_data.pop_front()));
        end
      end
      if (mix_valid) begin
        nmix++;
        check({tag, "_mix_data"}, 32'(mix_data), 32'(exp_mix));
      end
      if (overrun) nover++;
      if (stall > 0 && i == stall) check({tag, "_stall_rd"}, 32'(s1_readdata), 32'(stall_exp));
      if (busy) nbusy++;
      else begin
        done = 1;
        break;
      end
      sample_tick   = (i == extra_at);
      s1_chipselect = (i < stall);
      s1_clken      = (i < stall);
      s1_write      = 1'b0;
      s1_address    = {2'b00, 8'd9};
      step();
    end
    sample_tick   = 1'b0;
    s1_chipselect = 1'b0;
    s1_clken      = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    check({tag, "_mix_count"}, 32'(nmix), 32'd1);
    check({tag, "_overrun"}, 32'(nover), (extra_at >= 0) ? 32'd1 : 32'd0);
    check({tag, "_smp_left"}, 32'(exp_chan.size()), 32'd0);
    step();
    check({tag, "_mix_hold"}, 32'(mix_data), 32'(exp_mix));
    if (any) check({tag, "_smp_hold"}, 32'(smp_data), 32'(last_smp));
    check({tag, "_idle"}, 32'({busy, mix_valid, smp_valid}), 32'd0);
    $display("frame %s en=%b busy=%0d mix=%05h", tag, en, nbusy, mix_data);
  endtask

  initial begin
    rst_n = 1'b0;
    s1_address = '0; s1_chipselect = 1'b0; s1_clken = 1'b0; s1_write = 1'b0;
    s1_writedata = '0; s1_byteenable = '0; sample_tick = 1'b0;
    chan_enable = '0; phase_inc = '0;
    for (int c = 0; c < NB; c++) ph[c] = '0;
    repeat (3) step();
    check("rst_readdata", 32'(s1_readdata), 32'd0);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_strobes",  32'({smp_valid, mix_valid, overrun}), 32'd0);
    check("rst_smp_data", 32'(smp_data),    32'd0);
    check("rst_mix_data", 32'(mix_data),    32'd0);
    rst_n = 1'b1;
    step();

    for (int b = 0; b < NB; b++)
      for (int w = 0; w < 256; w++)
        cpu_write(b, w, 16'($urandom), 2'b11, 1'b1);

    // Byte-lane write: only the high byte changes.
    cpu_write(1, 5, 16'hABCD, 2'b11, 1'b1);
    cpu_write(1, 5, 16'h1234, 2'b10, 1'b1);
    cpu_read("be_hi", 1, 5);
    cpu_write(2, 7, 16'hBEEF, 2'b11, 1'b0);
    cpu_read("clken_low", 2, 7);
    cpu_write(3, 7, 16'hDEAD, 2'b11, 1'b1);
    cpu_read("bank_oob", 3, 7);

    for (int k = 0; k < 30; k++) begin
      int b, w;
      b = $urandom_range(0, 3);
      w = $urandom_range(0, 255);
      if ($urandom_range(0, 1)) cpu_write(b, w, 16'($urandom), 2'($urandom), 1'b1);
      else cpu_read("rand", b, w);
    end

    cpu_write(0, 0, 16'h0100, 2'b11, 1'b1);
    cpu_write(0, 1, 16'h0200, 2'b11, 1'b1);
    run_frame("ch0_a", 3'b001, 24'h010000, 24'h0, 24'h0, 0, -1);
    run_frame("ch0_b", 3'b001, 24'h010000, 24'h0, 24'h0, 0, -1);

    for (int c = 0; c < NB; c++) cpu_write(c, int'(ph[c][PW-1 -: AW]), 16'h7FFF, 2'b11, 1'b1);
    run_frame("max3", 3'b111, 24'h0, 24'h0, 24'h0, 0, -1);

    run_frame("stall", 3'b111, 24'h030000, 24'h050000, 24'h070000, 4, -1);
    run_frame("overrun", 3'b001, 24'h010000, 24'h0, 24'h0, 0, 1);
    run_frame("tick_mix", 3'b111, 24'h020000, 24'h010000, 24'h0, 0, 9);
    run_frame("all_off", 3'b000, 24'h010000, 24'h010000, 24'h010000, 0, -1);

    for (int k = 0; k < 15; k++) begin
      run_frame("rand", 3'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 0,
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1);
    end

    // Asynchronous reset in the middle of a frame.
    chan_enable = 3'b111;
    phase_inc   = '0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_strobes",  32'({smp_valid, mix_valid, overrun}), 32'd0);
    check("midrst_data",     32'({smp_chan, smp_data}), 32'd0);
    check("midrst_mix_data", 32'(mix_data), 32'd0);
    for (int c = 0; c < NB; c++) ph[c] = '0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("midrst_no_mix", 32'({mix_valid, busy}), 32'd0);
    end
    cpu_read("ram_kept", 1, 5);

    // Phase wrap: 0 -> 0xFF0000 -> wraps to 0 on the next increment.
    cpu_write(0, 255, 16'h5A5A, 2'b11, 1'b1);
    cpu_write(0, 0, 16'hC3A5, 2'b11, 1'b1);
    run_frame("wrap_a", 3'b001, 24'hFF0000, 24'h0, 24'h0, 0, -1);
    run_frame("wrap_b", 3'b001, 24'h010000, 24'h0, 24'h0, 0, -1);
    run_frame("wrap_c", 3'b001, 24'h000000, 24'h0, 24'h0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wavetable_bank.md
WAVETABLE_BANK -- requirements
Module: wavetable_bank

Interface
REQ-001 Parameters SHALL be:
  NUM_BANKS  3   channel/bank count, 1..8
  ADDR_W     8   word address width per bank
  DATA_W     16  sample width, multiple of 8
  PHASE_W    24  phase accumulator width, > ADDR_W
REQ-002 BANK_W SHALL be max(1, clog2(NUM_BANKS)); BE_W = DATA_W/8.
REQ-003 Ports (name  direction  width  meaning):
  clk_clk         in   1                  single clock
  reset_reset_n   in   1                  asynchronous active-low reset
  s1_address      in   BANK_W+ADDR_W      {bank, word}
  s1_chipselect   in   1                  CPU access request
  s1_clken        in   1                  CPU access qualifier
  s1_write        in   1                  1 write, 0 read
  s1_writedata    in   DATA_W             write data
  s1_byteenable   in   BE_W               byte lanes to write
  s1_readdata     out  DATA_W             read data, latency 1
  sample_tick     in   1                  one-cycle frame start strobe
  chan_enable     in   NUM_BANKS          per-channel play enable
  phase_inc       in   NUM_BANKS*PHASE_W  per-channel increment, channel 0 in LSBs
  smp_valid       out  1                  per-channel sample strobe
  smp_chan        out  BANK_W             channel of smp_data
  smp_data        out  DATA_W             signed sample
  mix_valid       out  1                  frame mix strobe
  mix_data        out  DATA_W+BANK_W      signed sum of frame samples
  busy            out  1                  frame in progress
  overrun         out  1                  one-cycle pulse, tick dropped

Function
REQ-004 A CPU access is acc = s1_chipselect & s1_clken; a write SHALL update only the enabled byte lanes of word s1_address in the addressed bank.
REQ-005 A CPU read SHALL drive s1_readdata from the addressed word on the cycle after acc; s1_readdata SHALL otherwise hold its last value.
REQ-006 A bank index >= NUM_BANKS SHALL ignore writes and return 0 on reads.
REQ-007 The playback FSM SHALL have states IDLE, FETCH, WAIT, EMIT, MIX.
REQ-008 IDLE: on sample_tick, SHALL latch chan_enable and phase_inc, set channel c=0, assert busy, and go to FETCH.
REQ-009 FETCH, channel c disabled: SHALL clear phase[c] to 0 and advance c without emitting.
REQ-010 FETCH, channel c enabled: SHALL issue a read of bank c at phase[c][PHASE_W-1 -: ADDR_W] and go to WAIT, unless a CPU acc targets bank c that cycle; then it SHALL stay in FETCH (CPU priority).
REQ-011 WAIT: one cycle for RAM read latency, then EMIT.
REQ-012 EMIT: SHALL pulse smp_valid with smp_chan=c and smp_data=read word, add it sign-extended into the mix accumulator, and set phase[c] += inc[c] modulo 2^PHASE_W (silent wrap).
REQ-013 After channel NUM_BANKS-1, SHALL go to MIX; MIX SHALL pulse mix_valid with the accumulator value, clear the accumulator, deassert busy, and return to IDLE.
REQ-014 An uncontended frame SHALL take 3 cycles per enabled channel, 1 per disabled channel, plus 1 for MIX; an all-disabled frame SHALL emit mix_data=0.
REQ-015 A sample_tick while busy SHALL be dropped and pulse overrun on the next cycle; the current frame SHALL be unaffected.
REQ-016 A sample_tick in the MIX cycle SHALL count as busy (dropped).
REQ-017 smp_data, smp_chan and mix_data SHALL hold their values between strobes.

Reset
REQ-018 Assertion SHALL immediately force IDLE, clear all phases and the accumulator, and drive every output to 0; a frame in progress SHALL be abandoned with no mix_valid.
REQ-019 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-020 Package wavetable_pkg SHALL hold the FSM state enum and the BANK_W width function.
REQ-021 One sub-module, wavetable_ram (single port, byte-enabled, 1-cycle read, ADDR_W x DATA_W), SHALL be instantiated NUM_BANKS times.

Verification
REQ-022 Write 0x1234 to bank 1 word 5 with byteenable=2'b10, then read it -> readdata 0x12xx, low byte unchanged, one cycle after acc.
REQ-023 Bank0 word0=0x0100, word1=0x0200; inc0=0x010000, others disabled; two ticks -> smp_data 0x0100 then 0x0200, mix_data equal to each.
REQ-024 All three enabled, words = 0x7FFF each -> mix_data = 0x17FFD, busy for 10 cycles, three smp_valid with smp_chan 0,1,2.
REQ-025 CPU read of bank 0 held 4 cycles during FETCH of channel 0 -> FSM stalls 4 cycles, sample still correct.
REQ-026 sample_tick two cycles after a prior tick -> overrun pulse, single mix_valid.
REQ-027 phase0=0xFFFFFF-0x00FFFF, inc0=0x010000 -> phase wraps to 0x000000, next read word 0; reset mid-frame -> outputs 0, no mix_valid.
